regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 32-entry register-file read port
//  among N_REQ requesters. It drives the select of the external Mux32to1,
//  samples the 32-bit mux output and returns it to the granted requester
//  with a one-cycle ack pulse. It sits between the datapath requesters and
//  the register-file read mux.
// PARAMETERS
//  N_REQ   4   number of requesters, 2..8
//  AW      5   register address width; drives the Mux32to1 sel
//  DW      32  data width of the mux output
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         asynchronous, active-high reset
//  req       in   N_REQ     per-requester read request, level; held until ack
//  addr      in   N_REQ*AW  flat: addr[i*AW +: AW] is requester i's register
//  mux_sel   out  AW        select to Mux32to1; registered
//  mux_out   in   DW        combinational output of Mux32to1
//  ack       out  N_REQ     one-hot, one-cycle pulse: rdata valid for that req
//  rdata     out  DW        captured read data; holds until next capture
//  busy      out  1         high while a read is in flight (state SEL)
//  grant_cnt out  N_REQ*16  present only with RDARB_GRANT_CNT_EN
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, mux_sel=0, ack=0, rdata=0,
//    busy=0, rr_ptr=N_REQ-1 (requester 0 has top priority first).
//  - FSM: IDLE, SEL.
//    IDLE: eligible = req & ~ack. If eligible!=0: g = first set bit
//      searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ). At the edge:
//      mux_sel<=addr[g], gnt<=g, rr_ptr<=g, go to SEL. Else stay in IDLE.
//    SEL: mux_out is settled. At the edge: rdata<=mux_out,
//      ack<=one-hot(gnt), go to IDLE.
//  - ack is registered and high for exactly one cycle, the cycle after SEL.
//  - Timing: req high before edge t -> mux_sel valid after t -> ack/rdata
//    valid after t+1. Latency is 2 cycles; throughput is 1 read per 2 cycles.
//  - The requester being acked is masked from arbitration in the same
//    IDLE cycle. It must drop req in that ack cycle. If req is still high
//    in the following cycle, that is a new request.
//  - A grant is committed once made. If req drops during SEL, the read
//    still completes and ack still pulses.
//  - addr is sampled only in the IDLE grant cycle. Later changes have no
//    effect on the in-flight read.
//  - mux_sel holds its last value while IDLE. busy = (state==SEL).
//  - All AW-bit addresses 0..2^AW-1 are legal, with no wrap-around. The
//    rr_ptr search wraps N_REQ-1 -> 0.
//  - rst asserted mid-read: the read is abandoned, no ack is issued, and
//    the block returns to reset values.
// CONFIGURATION
//  RDARB_GRANT_CNT_EN defined:
//  - grant_cnt[i*16 +: 16] counts grants to requester i, +1 each IDLE->SEL.
//  - Counters saturate at 16'hFFFF and reset to 0 on rst.
//  Not defined: the grant_cnt port and its counters are absent. All other
//  behaviour is identical.
// TESTING
//  1. Reset, then req=4'b0010, addr1=7, mux_out=7 -> mux_sel=7 after 1
//     cycle; ack=4'b0010 and rdata=7 after 2 cycles; busy high 1 cycle.
//  2. req=4'b1111 held; each drops req on its own ack; addr i=i+10
//     -> acks in order 0,1,2,3 every 2 cycles; rdata 10,11,12,13.
//  3. Req0 continuously re-requesting, req2 held -> grants alternate
//     0,2,0,2. Neither requester is starved.
//  4. addr0=31 then addr0=0 -> mux_sel 31 then 0; rdata matches
//     mux_out=31/0.
//  5. rst pulsed while busy=1 -> no ack, rdata=0, mux_sel=0. The next
//     req3 alone is granted normally.
//  6. (RDARB_GRANT_CNT_EN) 5 grants to req1 -> grant_cnt[31:16]=5. Force
//     16'hFFFF plus 1 more grant -> stays 16'hFFFF.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port (external Mux32to1) among N_REQ requesters.
// Optional per-requester saturating grant counters are built when RDARB_GRANT_CNT_EN is defined.
module regfile_read_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*AW-1:0]   addr,
    output logic [AW-1:0]         mux_sel,
    input  logic [DW-1:0]         mux_out,
    output logic [N_REQ-1:0]      ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy
`ifdef RDARB_GRANT_CNT_EN
    ,
    output logic [N_REQ*16-1:0]   grant_cnt
`endif
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE,
        SEL
    } state_t;

    state_t           r_state;
    logic [GW-1:0]    r_gnt;
    logic [GW-1:0]    r_rr_ptr;
    logic [AW-1:0]    r_mux_sel;
    logic [N_REQ-1:0] r_ack;
    logic [DW-1:0]    r_rdata;

    logic [N_REQ-1:0] w_eligible;
    logic             w_found;
    logic [GW-1:0]    w_g;
    logic [GW-1:0]    w_idx;
    logic [AW-1:0]    w_addr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_addr[i] = addr[i*AW +: AW];
        end
    end

    // The requester being acked this cycle is masked so it cannot win twice in a row.
    assign w_eligible = req & ~r_ack;

    // NOTE: every always_comb output gets a default before the loop, otherwise a latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_g     = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = GW'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_g     = w_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_rr_ptr  <= GW'(N_REQ - 1);
            r_mux_sel <= '0;
            r_ack     <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_mux_sel <= w_addr[w_g];
                        r_gnt     <= w_g;
                        r_rr_ptr  <= w_g;
                        r_state   <= SEL;
                    end
                end
                SEL: begin
                    // Grant is committed: the read completes even if req has dropped.
                    r_rdata <= mux_out;
                    r_ack   <= N_REQ'(1) << r_gnt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mux_sel = r_mux_sel;
    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign busy    = (r_state == SEL);

`ifdef RDARB_GRANT_CNT_EN
    logic [15:0] r_grant_cnt [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (r_state == IDLE && w_found && r_grant_cnt[w_g] != 16'hFFFF) begin
            r_grant_cnt[w_g] <= r_grant_cnt[w_g] + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[i*16 +: 16] = r_grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; the read mux is modelled as {tag, zeros, mux_sel}.
// Grant counter checks are compiled only with RDARB_GRANT_CNT_EN.
module tb_regfile_read_arbiter;

    localparam int N_REQ = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] addr;
    logic [AW-1:0]       mux_sel;
    logic [DW-1:0]       mux_out;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       rdata;
    logic                busy;
`ifdef RDARB_GRANT_CNT_EN
    logic [N_REQ*16-1:0] grant_cnt;
`endif

    logic [15:0] tag;
    int n_checks;
    int n_fail;

    int          log_req  [16];
    logic [31:0] log_data [16];
    int          log_cyc  [16];
    int          n_log;

    regfile_read_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy)
`ifdef RDARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    assign mux_out = {tag, {(DW-16-AW){1'b0}}, mux_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs n cycles; requesters in cont re-raise req whenever not acked, others drop on ack.
    task automatic run_and_log(input int n, input logic [N_REQ-1:0] cont);
        n_log = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (ack != '0 && n_log < 16) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (ack[i]) log_req[n_log] = i;
                end
                log_data[n_log] = rdata;
                log_cyc[n_log]  = c;
                n_log++;
            end
            req = (req & ~ack & ~cont) | (cont & ~ack);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        tag  = '0;
        @(negedge clk);
        if (mux_sel !== '0) begin n_fail++; $display("FAIL reset_mux_sel got=%0d exp=0", mux_sel); end
        n_checks++;
        if (ack !== '0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_checks++;
        if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        rst = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy got=%b exp=0", busy); end
        n_checks++;
    endtask

    task automatic test_single();
        do_reset();
        addr[1*AW +: AW] = 5'd7;
        req = 4'b0010;
        @(negedge clk);
        if (mux_sel !== 5'd7) begin n_fail++; $display("FAIL single_mux_sel got=%0d exp=7", mux_sel); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        n_checks++;
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_early_ack got=%b exp=0000", ack); end
        n_checks++;
        @(negedge clk);
        if (ack !== 4'b0010) begin n_fail++; $display("FAIL single_ack got=%b exp=0010", ack); end
        n_checks++;
        if (rdata !== 32'd7) begin n_fail++; $display("FAIL single_rdata got=%h exp=7", rdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        n_checks++;
        req = '0;
        @(negedge clk);
        if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
        n_checks++;
        if (rdata !== 32'd7) begin n_fail++; $display("FAIL single_rdata_hold got=%h exp=7", rdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_no_regrant got=%b exp=0", busy); end
        n_checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N_REQ; i++) addr[i*AW +: AW] = AW'(i + 10);
        req = 4'b1111;
        run_and_log(10, 4'b0000);
        if (n_log !== 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=4", n_log); end
        n_checks++;
        for (int j = 0; j < 4 && j < n_log; j++) begin
            if (log_req[j] !== j) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", j, log_req[j], j); end
            n_checks++;
            if (log_data[j] !== 32'(j + 10)) begin n_fail++; $display("FAIL rr_rdata[%0d] got=%0d exp=%0d", j, log_data[j], j + 10); end
            n_checks++;
            if (log_cyc[j] !== 2 * (j + 1)) begin n_fail++; $display("FAIL rr_cycle[%0d] got=%0d exp=%0d", j, log_cyc[j], 2 * (j + 1)); end
            n_checks++;
        end
    endtask

    task automatic test_fairness();
        int exp_req;
        do_reset();
        addr[0*AW +: AW] = 5'd3;
        addr[2*AW +: AW] = 5'd17;
        req = 4'b0101;
        run_and_log(12, 4'b0101);
        if (n_log !== 6) begin n_fail++; $display("FAIL fair_count got=%0d exp=6", n_log); end
        n_checks++;
        for (int j = 0; j < 6 && j < n_log; j++) begin
            exp_req = (j % 2 == 0) ? 0 : 2;
            if (log_req[j] !== exp_req) begin n_fail++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", j, log_req[j], exp_req); end
            n_checks++;
            if (log_data[j] !== ((exp_req == 0) ? 32'd3 : 32'd17)) begin
                n_fail++; $display("FAIL fair_rdata[%0d] got=%0d exp=%0d", j, log_data[j], (exp_req == 0) ? 3 : 17);
            end
            n_checks++;
        end
        req = '0;
    endtask

    task automatic test_addr_bounds();
        do_reset();
        addr[0*AW +: AW] = 5'd31;
        req = 4'b0001;
        @(negedge clk);
        if (mux_sel !== 5'd31) begin n_fail++; $display("FAIL bound_sel31 got=%0d exp=31", mux_sel); end
        n_checks++;
        @(negedge clk);
        if (rdata !== 32'd31) begin n_fail++; $display("FAIL bound_rdata31 got=%0d exp=31", rdata); end
        n_checks++;
        req = '0;
        @(negedge clk);
        addr[0*AW +: AW] = 5'd0;
        req = 4'b0001;
        @(negedge clk);
        if (mux_sel !== 5'd0) begin n_fail++; $display("FAIL bound_sel0 got=%0d exp=0", mux_sel); end
        n_checks++;
        @(negedge clk);
        if (ack !== 4'b0001) begin n_fail++; $display("FAIL bound_ack0 got=%b exp=0001", ack); end
        n_checks++;
        if (rdata !== 32'd0) begin n_fail++; $display("FAIL bound_rdata0 got=%0d exp=0", rdata); end
        n_checks++;
        req = '0;
    endtask

    task automatic test_commit();
        do_reset();
        tag = 16'hBEEF;
        addr[2*AW +: AW] = 5'd5;
        req = 4'b0100;
        @(negedge clk);
        addr[2*AW +: AW] = 5'd6;
        req = '0;
        if (mux_sel !== 5'd5) begin n_fail++; $display("FAIL commit_sel got=%0d exp=5", mux_sel); end
        n_checks++;
        @(negedge clk);
        if (ack !== 4'b0100) begin n_fail++; $display("FAIL commit_ack got=%b exp=0100", ack); end
        n_checks++;
        if (rdata !== 32'hBEEF_0005) begin n_fail++; $display("FAIL commit_rdata got=%h exp=beef0005", rdata); end
        n_checks++;
        tag = '0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        addr[1*AW +: AW] = 5'd9;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        addr[1*AW +: AW] = 5'd20;
        req = 4'b0010;
        @(negedge clk);
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        n_checks++;
        rst = 1'b1;
        req = '0;
        #1;
        if (mux_sel !== '0) begin n_fail++; $display("FAIL midrst_mux_sel got=%0d exp=0", mux_sel); end
        n_checks++;
        if (rdata !== '0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (ack !== '0) begin n_fail++; $display("FAIL midrst_no_ack got=%b exp=0000", ack); end
        n_checks++;
        addr[3*AW +: AW] = 5'd21;
        req = 4'b1000;
        @(negedge clk);
        if (mux_sel !== 5'd21) begin n_fail++; $display("FAIL midrst_req3_sel got=%0d exp=21", mux_sel); end
        n_checks++;
        @(negedge clk);
        if (ack !== 4'b1000) begin n_fail++; $display("FAIL midrst_req3_ack got=%b exp=1000", ack); end
        n_checks++;
        if (rdata !== 32'd21) begin n_fail++; $display("FAIL midrst_req3_rdata got=%0d exp=21", rdata); end
        n_checks++;
        req = '0;
    endtask

`ifdef RDARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        do_reset();
        addr[1*AW +: AW] = 5'd4;
        for (int n = 0; n < 5; n++) begin
            req = 4'b0010;
            @(negedge clk);
            @(negedge clk);
            req = '0;
            @(negedge clk);
        end
        if (grant_cnt[31:16] !== 16'd5) begin n_fail++; $display("FAIL cnt_req1 got=%0d exp=5", grant_cnt[31:16]); end
        n_checks++;
        if (grant_cnt[15:0] !== 16'd0) begin n_fail++; $display("FAIL cnt_req0 got=%0d exp=0", grant_cnt[15:0]); end
        n_checks++;
        force dut.r_grant_cnt[1] = 16'hFFFF;
        @(negedge clk);
        release dut.r_grant_cnt[1];
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        if (grant_cnt[31:16] !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate got=%h exp=ffff", grant_cnt[31:16]); end
        n_checks++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_addr_bounds();
        test_commit();
        test_reset_mid_read();
`ifdef RDARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
